// File: rtl/ip_fixer_process.sv
// Streams packets from the ip_fixer input FIFO and splices the corrected IPv4
// total length and header checksum into data words D2 and D3.
//
// Handshake: a word moves when the FIFO is non-empty, out_rdy is high, the
// sequencer is not waiting for a preprocess result and reset is low.
// in_fifo_rd_en pops the head word in that same cycle. The word then appears
// on out_data/out_ctrl with out_wr=1 one cycle later. new_data_rd_en pops the
// preprocess result in the cycle the packet's EOP word moves.
module ip_fixer_process #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_fifo_data,
  input  logic [CTRL_WIDTH-1:0] in_fifo_ctrl,
  input  logic                  in_fifo_empty,
  output logic                  in_fifo_rd_en,
  input  logic [15:0]           new_ip_length,
  input  logic [15:0]           new_ip_checksum,
  input  logic                  pkt_is_ip,
  input  logic                  new_data_avail,
  output logic                  new_data_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           num_pkts_fixed,
  output logic [6:0]            state_dbg
);

  typedef enum logic [6:0] {
    MOD_HDRS    = 7'b0000001,
    WAIT_RESULT = 7'b0000010,
    WORD_0      = 7'b0000100,
    WORD_1      = 7'b0001000,
    WORD_2      = 7'b0010000,
    WORD_3      = 7'b0100000,
    PAYLOAD     = 7'b1000000
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;
  logic [31:0]           num_pkts_fixed_q, num_pkts_fixed_d;
  logic                  head_is_ctrl;
  logic                  move;
  logic [DATA_WIDTH-1:0] word_mux;

  always_comb begin
    head_is_ctrl     = (in_fifo_ctrl != '0);
    move             = !in_fifo_empty && out_rdy && (state_q != WAIT_RESULT) && !reset;
    in_fifo_rd_en    = move;
    new_data_rd_en   = 1'b0;
    state_d          = state_q;
    word_mux         = in_fifo_data;
    num_pkts_fixed_d = num_pkts_fixed_q;

    case (state_q)
      MOD_HDRS: begin
        // The first data word stays in the FIFO until the result is ready.
        if (!in_fifo_empty && !head_is_ctrl) begin
          in_fifo_rd_en = 1'b0;
          state_d       = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (new_data_avail) state_d = WORD_0;
      end
      WORD_0: begin
        if (move) state_d = WORD_1;
      end
      WORD_1: begin
        if (move) state_d = WORD_2;
      end
      WORD_2: begin
        if (pkt_is_ip) word_mux = {new_ip_length, in_fifo_data[DATA_WIDTH-17:0]};
        if (move) state_d = WORD_3;
      end
      WORD_3: begin
        if (pkt_is_ip) word_mux = {new_ip_checksum, in_fifo_data[DATA_WIDTH-17:0]};
        if (move) begin
          state_d = PAYLOAD;
          if (pkt_is_ip) num_pkts_fixed_d = num_pkts_fixed_q + 32'd1;
        end
      end
      PAYLOAD: begin
        if (move && head_is_ctrl) begin
          new_data_rd_en = 1'b1;
          state_d        = MOD_HDRS;
        end
      end
      default: state_d = MOD_HDRS;
    endcase

    out_wr_d   = in_fifo_rd_en;
    out_data_d = in_fifo_rd_en ? word_mux : out_data_q;
    out_ctrl_d = in_fifo_rd_en ? in_fifo_ctrl : out_ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= MOD_HDRS;
      out_data_q       <= '0;
      out_ctrl_q       <= '0;
      out_wr_q         <= 1'b0;
      num_pkts_fixed_q <= '0;
    end else begin
      state_q          <= state_d;
      out_data_q       <= out_data_d;
      out_ctrl_q       <= out_ctrl_d;
      out_wr_q         <= out_wr_d;
      num_pkts_fixed_q <= num_pkts_fixed_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_ctrl       = out_ctrl_q;
  assign out_wr         = out_wr_q;
  assign num_pkts_fixed = num_pkts_fixed_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_ip_fixer_process.sv
// Bench for ip_fixer_process: queue-modelled input and result FIFOs, a word
// scoreboard, table-driven directed packets, corner sequences and random traffic.
module tb_ip_fixer_process;

  logic        clk;
  logic        reset;
  logic [63:0] in_fifo_data;
  logic [7:0]  in_fifo_ctrl;
  logic        in_fifo_empty;
  logic        in_fifo_rd_en;
  logic [15:0] new_ip_length;
  logic [15:0] new_ip_checksum;
  logic        pkt_is_ip;
  logic        new_data_avail;
  logic        new_data_rd_en;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [31:0] num_pkts_fixed;
  logic [6:0]  state_dbg;

  ip_fixer_process dut (
    .clk             (clk),
    .reset           (reset),
    .in_fifo_data    (in_fifo_data),
    .in_fifo_ctrl    (in_fifo_ctrl),
    .in_fifo_empty   (in_fifo_empty),
    .in_fifo_rd_en   (in_fifo_rd_en),
    .new_ip_length   (new_ip_length),
    .new_ip_checksum (new_ip_checksum),
    .pkt_is_ip       (pkt_is_ip),
    .new_data_avail  (new_data_avail),
    .new_data_rd_en  (new_data_rd_en),
    .out_data        (out_data),
    .out_ctrl        (out_ctrl),
    .out_wr          (out_wr),
    .out_rdy         (out_rdy),
    .num_pkts_fixed  (num_pkts_fixed),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [6:0] ST_MOD_HDRS = 7'b0000001;

  typedef struct {
    bit          ip;
    logic [15:0] len;
    logic [15:0] csum;
    logic [15:0] d2_hi;
    logic [15:0] d3_hi;
    logic [15:0] exp_d2_hi;
    logic [15:0] exp_d3_hi;
    int          exp_fixed_inc;
  } vec_t;

  logic [71:0] in_q[$];
  logic [71:0] exp_q[$];
  logic [71:0] pkt_q[$];
  logic [32:0] res_q[$];
  int          wr_cyc_q[$];

  int  passed = 0;
  int  total = 0;
  int  cyc = 0;
  int  nd_count = 0;
  int  exp_fixed = 0;
  bit  hold_res = 0;
  bit  rdy_random = 0;
  bit  obs_wr;

  task automatic check(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver
  task automatic apply_inputs();
    in_fifo_empty = (in_q.size() == 0);
    {in_fifo_ctrl, in_fifo_data} = in_fifo_empty ? 72'h0 : in_q[0];
    new_data_avail = (res_q.size() != 0) && !hold_res;
    {pkt_is_ip, new_ip_length, new_ip_checksum} = (res_q.size() != 0) ? res_q[0] : 33'h0;
    out_rdy = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic step();
    logic [71:0] e;
    bit rd, nd;
    @(negedge clk);
    cyc++;
    obs_wr = out_wr;
    if (out_wr) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_word", {out_ctrl, out_data}, 72'h0);
      end else begin
        e = exp_q.pop_front();
        check({out_ctrl, out_data} == e, "out_word", {out_ctrl, out_data}, e);
      end
    end
    rd = in_fifo_rd_en;
    nd = new_data_rd_en;
    @(posedge clk);
    #1;
    if (rd && in_q.size() != 0) void'(in_q.pop_front());
    if (nd) begin
      nd_count++;
      if (res_q.size() != 0) void'(res_q.pop_front());
    end
    apply_inputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(n < budget, "drain_budget", 72'(n), 72'(budget));
  endtask

  task automatic build_pkt(input int nhdr, input int ndata, input bit ip,
                           input logic [15:0] d2_hi, input logic [15:0] d3_hi);
    logic [63:0] d;
    logic [7:0]  c;
    pkt_q.delete();
    for (int h = 0; h < nhdr; h++) pkt_q.push_back({8'hFF, $urandom, $urandom});
    for (int i = 0; i < ndata; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) d[31:16] = ip ? 16'h0800 : 16'h0806;
      if (i == 2) d[63:48] = d2_hi;
      if (i == 3) d[63:48] = d3_hi;
      c = 8'h00;
      if (i == ndata - 1) c = 8'h01 << $urandom_range(0, 7);
      pkt_q.push_back({c, d});
    end
    foreach (pkt_q[k]) in_q.push_back(pkt_q[k]);
  endtask

  task automatic send_vec(input vec_t v);
    logic [71:0] w;
    build_pkt(1, 10, v.ip, v.d2_hi, v.d3_hi);
    res_q.push_back({v.ip, v.len, v.csum});
    foreach (pkt_q[k]) begin
      w = pkt_q[k];
      if (k == 3) w[63:48] = v.exp_d2_hi;
      if (k == 4) w[63:48] = v.exp_d3_hi;
      exp_q.push_back(w);
    end
    exp_fixed += v.exp_fixed_inc;
    apply_inputs();
  endtask

  // Reference model: IP packets get length in D2 top half, checksum in D3 top half.
  task automatic send_random(input int nhdr_in, input int ndata_in, input int ip_sel);
    int nhdr, ndata;
    bit ip;
    logic [15:0] len, csum;
    logic [71:0] w;
    nhdr  = (nhdr_in > 0) ? nhdr_in : int'($urandom_range(1, 3));
    ndata = (ndata_in > 0) ? ndata_in : int'($urandom_range(6, 12));
    ip    = (ip_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(ip_sel);
    len   = 16'($urandom);
    csum  = 16'($urandom);
    build_pkt(nhdr, ndata, ip, 16'($urandom), 16'($urandom));
    res_q.push_back({ip, len, csum});
    foreach (pkt_q[k]) begin
      w = pkt_q[k];
      if (ip && k == nhdr + 2) w[63:48] = len;
      if (ip && k == nhdr + 3) w[63:48] = csum;
      exp_q.push_back(w);
    end
    if (ip) exp_fixed++;
    apply_inputs();
  endtask

  vec_t vecs[4];

  initial begin
    int nd0, len1, n;
    vecs[0] = '{1'b1, 16'h003C, 16'hB1E6, 16'h0000, 16'hFFFF, 16'h003C, 16'hB1E6, 1};
    vecs[1] = '{1'b0, 16'h1234, 16'h5678, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 0};
    vecs[2] = '{1'b1, 16'h05DC, 16'h0001, 16'h05DC, 16'h1234, 16'h05DC, 16'h0001, 1};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1};

    reset = 1'b1;
    apply_inputs();
    send_random(1, 8, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(out_wr == 1'b0, "reset_out_wr", 72'(out_wr), 72'h0);
    check(out_data == 64'h0, "reset_out_data", 72'(out_data), 72'h0);
    check(out_ctrl == 8'h0, "reset_out_ctrl", 72'(out_ctrl), 72'h0);
    check(num_pkts_fixed == 32'h0, "reset_num_fixed", 72'(num_pkts_fixed), 72'h0);
    check(state_dbg == ST_MOD_HDRS, "reset_state", 72'(state_dbg), 72'(ST_MOD_HDRS));
    check(in_fifo_rd_en == 1'b0, "reset_rd_en", 72'(in_fifo_rd_en), 72'h0);
    check(new_data_rd_en == 1'b0, "reset_nd_rd_en", 72'(new_data_rd_en), 72'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_inputs();
    drain(200);
    check(num_pkts_fixed == 32'(exp_fixed), "first_pkt_fixed", 72'(num_pkts_fixed), 72'(exp_fixed));

    // table-driven directed packets
    for (int i = 0; i < 4; i++) begin
      nd0 = nd_count;
      send_vec(vecs[i]);
      drain(200);
      check(nd_count - nd0 == 1, "vec_nd_pulses", 72'(nd_count - nd0), 72'd1);
      check(num_pkts_fixed == 32'(exp_fixed), "vec_num_fixed", 72'(num_pkts_fixed), 72'(exp_fixed));
    end

    // result withheld: only the module header moves
    hold_res = 1'b1;
    send_random(1, 8, 1);
    wr_cyc_q.delete();
    repeat (22) step();
    check(in_q.size() == 8, "hold_no_d0_read", 72'(in_q.size()), 72'd8);
    check(wr_cyc_q.size() == 1, "hold_only_header_out", 72'(wr_cyc_q.size()), 72'd1);
    check(obs_wr == 1'b0, "hold_out_wr_low", 72'(obs_wr), 72'h0);
    hold_res = 1'b0;
    apply_inputs();
    step();
    check(obs_wr == 1'b0, "release_cycle0", 72'(obs_wr), 72'h0);
    step();
    check(obs_wr == 1'b0, "release_cycle1", 72'(obs_wr), 72'h0);
    step();
    check(obs_wr == 1'b1, "release_d0_out", 72'(obs_wr), 72'h1);
    drain(200);

    // back-to-back packets with results ready
    wr_cyc_q.delete();
    send_random(0, 0, 2);
    len1 = pkt_q.size();
    send_random(0, 0, 2);
    drain(400);
    if (wr_cyc_q.size() > len1)
      check(wr_cyc_q[len1] - wr_cyc_q[len1-1] == 1, "b2b_eop_to_hdr",
            72'(wr_cyc_q[len1] - wr_cyc_q[len1-1]), 72'd1);
    else
      check(1'b0, "b2b_word_count", 72'(wr_cyc_q.size()), 72'(len1 + 1));

    // reset during PAYLOAD
    send_random(1, 10, 1);
    n = 0;
    while (in_q.size() > 3 && n < 100) begin
      step();
      n++;
    end
    check(n < 100, "reach_payload", 72'(n), 72'd100);
    reset = 1'b1;
    step();
    @(negedge clk);
    check(out_wr == 1'b0, "midreset_out_wr", 72'(out_wr), 72'h0);
    check(num_pkts_fixed == 32'h0, "midreset_num_fixed", 72'(num_pkts_fixed), 72'h0);
    check(state_dbg == ST_MOD_HDRS, "midreset_state", 72'(state_dbg), 72'(ST_MOD_HDRS));
    in_q.delete();
    exp_q.delete();
    res_q.delete();
    exp_fixed = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_inputs();
    send_random(2, 9, 1);
    drain(200);
    check(num_pkts_fixed == 32'd1, "post_reset_fixed", 72'(num_pkts_fixed), 72'd1);

    // random traffic with 50% out_rdy
    rdy_random = 1'b1;
    nd0 = nd_count;
    for (int p = 0; p < 100; p++) send_random(0, 0, 2);
    drain(20000);
    check(nd_count - nd0 == 100, "random_nd_pulses", 72'(nd_count - nd0), 72'd100);
    check(num_pkts_fixed == 32'(exp_fixed), "random_num_fixed", 72'(num_pkts_fixed), 72'(exp_fixed));
    check(res_q.size() == 0, "random_results_consumed", 72'(res_q.size()), 72'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ip_fixer_process.md
# ip_fixer_process

Sequencer that streams each packet out of the ip_fixer input FIFO, waits for ip_fixer_preprocess to publish the packet's corrected IPv4 total length and header checksum, and splices those values into the outgoing header words. IP packets leave with consistent length/checksum fields; non-IP packets pass through unchanged. It sits between the input FIFO and the next pipeline stage, and pops one preprocess result per packet.

## Interface
- DATA_WIDTH, 64, datapath width; only 64 supported.
- CTRL_WIDTH, DATA_WIDTH/8, control width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_fifo_data  in  64  head word of the fall-through input FIFO, valid when !in_fifo_empty.
- in_fifo_ctrl  in  8  ctrl of the head word.
- in_fifo_empty  in  1  input FIFO empty.
- in_fifo_rd_en  out  1  pops the head word; combinational.
- new_ip_length  in  16  corrected IP total length from preprocess.
- new_ip_checksum  in  16  corrected IP header checksum, already complemented.
- pkt_is_ip  in  1  ethertype was 0x0800.
- new_data_avail  in  1  preprocess result FIFO non-empty.
- new_data_rd_en  out  1  pops one preprocess result; combinational, one pulse per packet.
- out_data  out  64  registered output word.
- out_ctrl  out  8  registered output ctrl.
- out_wr  out  1  registered write strobe.
- out_rdy  in  1  downstream can accept a word.
- num_pkts_fixed  out  32  count of IP packets rewritten; wraps.

## Operation
- Packet layout: module header words (ctrl≠0), then data words D0..Dn (ctrl=0), last word ctrl≠0 (EOP). D1[31:16] is ethertype. D2[63:48] is total length. D3[63:48] is header checksum.
- Move condition: move = !in_fifo_empty && out_rdy && (state≠WAIT_RESULT). in_fifo_rd_en = move.
- States (one-hot):
  - MOD_HDRS: forward words while ctrl≠0. On the first ctrl=0 word, do not read it; go to WAIT_RESULT.
  - WAIT_RESULT: no reads. When new_data_avail=1, go to WORD_0. Preprocess publishes its result only after seeing D5, so the input FIFO must be able to hold at least 6 data words plus the header words.
  - WORD_0: forward D0 on move, then go to WORD_1.
  - WORD_1: forward D1 on move, then go to WORD_2.
  - WORD_2: on move, output {new_ip_length, D2[47:0]} if pkt_is_ip, else D2 unchanged. Go to WORD_3.
  - WORD_3: on move, output {new_ip_checksum, D3[47:0]} if pkt_is_ip, else D3 unchanged. If pkt_is_ip, increment num_pkts_fixed. Go to PAYLOAD.
  - PAYLOAD: forward words on move. On a moved word with ctrl≠0 (EOP): assert new_data_rd_en for that cycle and go to MOD_HDRS.
- Packets shorter than 6 data words are excluded by the upstream minimum frame size and are not handled.
- new_ip_length, new_ip_checksum and pkt_is_ip are sampled directly from the preprocess FIFO head. They stay stable until new_data_rd_en.
- Illegal or unknown state: return to MOD_HDRS.

## Timing
- Reset values: out_wr=0, out_data=0, out_ctrl=0, num_pkts_fixed=0, state=MOD_HDRS. in_fifo_rd_en and new_data_rd_en are 0 during reset.
- Latency: a word read in cycle t appears on out_* with out_wr=1 in cycle t+1. out_wr is 0 in every cycle after a cycle with no move.
- out_rdy=0 stalls in any state; no word is dropped or duplicated.
- WAIT_RESULT to WORD_0 costs one cycle with no read. D0 can move at the earliest one cycle after new_data_avail is seen.
- EOP of packet N and the module header of packet N+1 may move on consecutive cycles. There is no bubble except WAIT_RESULT.
- Reset mid-packet: state returns to MOD_HDRS. The block does not repair FIFO contents; a system-wide reset clears the FIFOs.
- num_pkts_fixed wraps from 0xFFFFFFFF to 0.

## Test plan
- IP packet, 1 module header (len 74 bytes), D2[63:48]=0x0000, D3[63:48]=0xFFFF, result len=0x003C, csum=0xB1E6, out_rdy=1 -> output D2[63:48]=0x003C and D3[63:48]=0xB1E6; all other bits identical to input; new_data_rd_en pulses once on EOP; num_pkts_fixed=1.
- ARP packet, pkt_is_ip=0 -> output identical to input word-for-word; new_data_rd_en pulses once; num_pkts_fixed unchanged.
- new_data_avail held low 20 cycles after the module header -> no D0 read and out_wr=0 while it is low. Raise it -> D0 appears 2 cycles later.
- Random out_rdy toggling (50%) over 100 back-to-back packets -> output stream equals the golden model; no loss or duplication; exactly 100 new_data_rd_en pulses.
- Back-to-back packets with results available in advance -> EOP of packet 1 and header of packet 2 show out_wr=1 in consecutive cycles.
- Reset asserted during PAYLOAD -> the next cycle has out_wr=0, num_pkts_fixed=0, state=MOD_HDRS. A fresh packet after reset is fixed correctly.
